// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard unit: forwarding selects and the load result source.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register busy bits and outstanding-count tracking for long-latency (MDU) writes.
module reg_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned AW              = 5,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_issue,
    input  logic             i_mem_stall,
    input  logic [AW-1:0]    i_issue_rd,
    input  logic             i_done,
    input  logic [AW-1:0]    i_done_rd,
    output logic [2**AW-1:0] o_busy,
    output logic             o_full
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [2**AW-1:0] r_busy;
    logic [CNT_W-1:0] r_count;
    logic             w_accept;
    logic             w_done;
    logic             w_full;

    assign w_accept = i_issue && !i_mem_stall && (i_issue_rd != '0);
    // A completion with nothing outstanding is dropped so the count cannot wrap.
    assign w_done   = i_done && (r_count != '0);
    assign w_full   = (r_count == CNT_W'(MAX_OUTSTANDING));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_count <= '0;
        end else begin
            if (w_done)
                r_busy[i_done_rd] <= 1'b0;
            if (w_accept)
                r_busy[i_issue_rd] <= 1'b1;
            if (w_accept && !w_done && !w_full)
                r_count <= r_count + 1'b1;
            else if (w_done && !w_accept)
                r_count <= r_count - 1'b1;
        end
    end

    a_done_without_outstanding: assert property (
        @(posedge clk) disable iff (rst) !(i_done && r_count == '0)
    );

    assign o_busy = r_busy;
    assign o_full = w_full;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard control: forwarding, scoreboard/load-use stalls, branch flush and memory freeze.
// Optional stall-cycle perf counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned REG_FILE_ADDRESS_WIDTH = 5,
    parameter int unsigned MAX_OUTSTANDING        = 2,
    parameter int unsigned LOAD_BUBBLES           = 1,
    parameter int unsigned PERF_CNT_WIDTH         = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs1D,
    input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs2D,
    input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdD,
    input  logic                              RegWriteD,
    input  logic                              LongOpD,
    input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs1E,
    input  logic [REG_FILE_ADDRESS_WIDTH-1:0] Rs2E,
    input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdE,
    input  logic [1:0]                        ResultSrcE,
    input  logic                              PCSrcE,
    input  logic                              LongIssueE,
    input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdM,
    input  logic [REG_FILE_ADDRESS_WIDTH-1:0] RdW,
    input  logic                              RegWriteM,
    input  logic                              RegWriteW,
    input  logic                              LongDoneW,
    input  logic [REG_FILE_ADDRESS_WIDTH-1:0] LongRdW,
    input  logic                              MemStallM,
    output logic [1:0]                        ForwardAE,
    output logic [1:0]                        ForwardBE,
    output logic                              StallFetch,
    output logic                              StallDecode,
    output logic                              StallExecute,
    output logic                              StallMemory,
    output logic                              FlushDecode,
    output logic                              FlushExecute,
    output logic                              FlushWriteback,
    output logic                              ScoreboardFull,
    output logic [PERF_CNT_WIDTH-1:0]         StallCycleCount
);

    localparam int unsigned AW    = REG_FILE_ADDRESS_WIDTH;
    localparam int unsigned BUB_W = 3;

    logic [2**AW-1:0] w_busy;
    logic             w_full;
    logic             w_sbD;
    logic             w_luD;
    logic             w_stallD;
    logic [BUB_W-1:0] r_bubbles;

    reg_scoreboard #(
        .AW              (AW),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_reg_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .i_issue     (LongIssueE),
        .i_mem_stall (MemStallM),
        .i_issue_rd  (RdE),
        .i_done      (LongDoneW),
        .i_done_rd   (LongRdW),
        .o_busy      (w_busy),
        .o_full      (w_full)
    );

    assign ScoreboardFull = w_full;

    always_comb begin
        ForwardAE = FWD_REG;
        ForwardBE = FWD_REG;
        if (Rs1E != '0 && RegWriteM && RdM == Rs1E)      ForwardAE = FWD_MEM;
        else if (Rs1E != '0 && RegWriteW && RdW == Rs1E) ForwardAE = FWD_WB;
        if (Rs2E != '0 && RegWriteM && RdM == Rs2E)      ForwardBE = FWD_MEM;
        else if (Rs2E != '0 && RegWriteW && RdW == Rs2E) ForwardBE = FWD_WB;
    end

    assign w_sbD = (Rs1D != '0 && w_busy[Rs1D]) ||
                   (Rs2D != '0 && w_busy[Rs2D]) ||
                   (RegWriteD && w_busy[RdD])   ||
                   (LongOpD && w_full);
    assign w_luD = (ResultSrcE == RESULT_SRC_LOAD) && (RdE != '0) &&
                   ((RdE == Rs1D) || (RdE == Rs2D));
    assign w_stallD = w_sbD || w_luD || (r_bubbles != '0);

    // The first bubble comes from luD itself; the counter covers the remaining ones.
    always_ff @(posedge clk) begin
        if (rst)
            r_bubbles <= '0;
        else if (!MemStallM) begin
            if (PCSrcE)
                r_bubbles <= '0;
            else if (r_bubbles != '0)
                r_bubbles <= r_bubbles - 1'b1;
            else if (w_luD)
                r_bubbles <= BUB_W'(LOAD_BUBBLES - 1);
        end
    end

    always_comb begin
        StallFetch     = 1'b0;
        StallDecode    = 1'b0;
        StallExecute   = 1'b0;
        StallMemory    = 1'b0;
        FlushDecode    = 1'b0;
        FlushExecute   = 1'b0;
        FlushWriteback = 1'b0;
        if (rst) begin
            StallFetch = 1'b0;
        end else if (MemStallM) begin
            StallFetch     = 1'b1;
            StallDecode    = 1'b1;
            StallExecute   = 1'b1;
            StallMemory    = 1'b1;
            FlushWriteback = 1'b1;
        end else if (PCSrcE) begin
            FlushDecode  = 1'b1;
            FlushExecute = 1'b1;
        end else if (w_stallD) begin
            StallFetch   = 1'b1;
            StallDecode  = 1'b1;
            FlushExecute = 1'b1;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_CNT_WIDTH-1:0] r_stall_cycles;

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cycles <= '0;
        else if (StallFetch && r_stall_cycles != '1)
            r_stall_cycles <= r_stall_cycles + 1'b1;
    end

    assign StallCycleCount = r_stall_cycles;
`else
    assign StallCycleCount = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (MAX_OUTSTANDING=2, LOAD_BUBBLES=2).
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, LongRdW;
    logic       RegWriteD, LongOpD, PCSrcE, LongIssueE;
    logic       RegWriteM, RegWriteW, LongDoneW, MemStallM;
    logic [1:0] ResultSrcE;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallFetch, StallDecode, StallExecute, StallMemory;
    logic       FlushDecode, FlushExecute, FlushWriteback, ScoreboardFull;
    logic [31:0] StallCycleCount;

    int unsigned chk_count = 0;
    int unsigned err_count = 0;

    // {StallFetch, StallDecode, StallExecute, StallMemory, FlushDecode, FlushExecute, FlushWriteback}
    localparam logic [6:0] CTL_NONE  = 7'b0000_000;
    localparam logic [6:0] CTL_STALL = 7'b1100_010;
    localparam logic [6:0] CTL_MEM   = 7'b1111_001;
    localparam logic [6:0] CTL_FLUSH = 7'b0000_110;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .REG_FILE_ADDRESS_WIDTH (5),
        .MAX_OUTSTANDING        (2),
        .LOAD_BUBBLES           (2),
        .PERF_CNT_WIDTH         (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .Rs1D            (Rs1D),
        .Rs2D            (Rs2D),
        .RdD             (RdD),
        .RegWriteD       (RegWriteD),
        .LongOpD         (LongOpD),
        .Rs1E            (Rs1E),
        .Rs2E            (Rs2E),
        .RdE             (RdE),
        .ResultSrcE      (ResultSrcE),
        .PCSrcE          (PCSrcE),
        .LongIssueE      (LongIssueE),
        .RdM             (RdM),
        .RdW             (RdW),
        .RegWriteM       (RegWriteM),
        .RegWriteW       (RegWriteW),
        .LongDoneW       (LongDoneW),
        .LongRdW         (LongRdW),
        .MemStallM       (MemStallM),
        .ForwardAE       (ForwardAE),
        .ForwardBE       (ForwardBE),
        .StallFetch      (StallFetch),
        .StallDecode     (StallDecode),
        .StallExecute    (StallExecute),
        .StallMemory     (StallMemory),
        .FlushDecode     (FlushDecode),
        .FlushExecute    (FlushExecute),
        .FlushWriteback  (FlushWriteback),
        .ScoreboardFull  (ScoreboardFull),
        .StallCycleCount (StallCycleCount)
    );

    function automatic logic [6:0] ctl();
        return {StallFetch, StallDecode, StallExecute, StallMemory,
                FlushDecode, FlushExecute, FlushWriteback};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        Rs1D = '0; Rs2D = '0; RdD = '0; RegWriteD = 1'b0; LongOpD = 1'b0;
        Rs1E = '0; Rs2E = '0; RdE = '0; ResultSrcE = 2'b00; PCSrcE = 1'b0;
        LongIssueE = 1'b0; RdM = '0; RdW = '0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        LongDoneW = 1'b0; LongRdW = '0; MemStallM = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        MemStallM = 1'b1;
        PCSrcE = 1'b1;
        tick(); tick();
        check_eq("reset_ctl_zero", {25'd0, ctl()}, {25'd0, CTL_NONE});
        check_eq("reset_full", {31'd0, ScoreboardFull}, 32'd0);
        check_eq("reset_perf", StallCycleCount, 32'd0);
        rst = 1'b0;
        idle();
        tick();

        // Forwarding
        RdM = 5'd5; RegWriteM = 1'b1; RdW = 5'd5; RegWriteW = 1'b1; Rs1E = 5'd5;
        settle();
        check_eq("fwdA_mem_prio", {30'd0, ForwardAE}, 32'd2);
        check_eq("fwdB_idle", {30'd0, ForwardBE}, 32'd0);
        RegWriteM = 1'b0; Rs2E = 5'd5;
        settle();
        check_eq("fwdA_wb", {30'd0, ForwardAE}, 32'd1);
        check_eq("fwdB_wb", {30'd0, ForwardBE}, 32'd1);
        Rs1E = '0; RdM = '0; RegWriteM = 1'b1; RdW = '0;
        settle();
        check_eq("fwdA_x0", {30'd0, ForwardAE}, 32'd0);
        idle();
        tick();

        // Load-use, two bubbles
        ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        settle();
        check_eq("lu_cycle1", {25'd0, ctl()}, {25'd0, CTL_STALL});
        tick();
        ResultSrcE = 2'b00; RdE = '0;
        settle();
        check_eq("lu_cycle2", {25'd0, ctl()}, {25'd0, CTL_STALL});
        tick();
        check_eq("lu_done", {25'd0, ctl()}, {25'd0, CTL_NONE});
        idle();
        tick();

        // Scoreboard RAW on x9
        LongIssueE = 1'b1; RdE = 5'd9;
        settle();
        check_eq("sb_issue_same_cycle", {31'd0, StallDecode}, 32'd0);
        tick();
        idle(); Rs1D = 5'd9;
        settle();
        check_eq("sb_raw_stall", {31'd0, StallDecode}, 32'd1);
        tick();
        LongDoneW = 1'b1; LongRdW = 5'd9;
        settle();
        check_eq("sb_done_cycle_still_busy", {31'd0, StallDecode}, 32'd1);
        tick();
        LongDoneW = 1'b0;
        settle();
        check_eq("sb_cleared", {31'd0, StallDecode}, 32'd0);
        idle(); LongIssueE = 1'b1; RdE = 5'd9;
        tick();
        LongDoneW = 1'b1; LongRdW = 5'd9;
        tick();
        idle(); Rs1D = 5'd9;
        settle();
        check_eq("sb_set_wins", {31'd0, StallDecode}, 32'd1);
        idle(); RegWriteD = 1'b1; RdD = 5'd9;
        settle();
        check_eq("sb_waw", {31'd0, StallDecode}, 32'd1);
        idle(); LongDoneW = 1'b1; LongRdW = 5'd9;
        tick();
        idle(); Rs1D = 5'd9;
        settle();
        check_eq("sb_cleared_again", {31'd0, StallDecode}, 32'd0);
        idle();

        // Structural full
        LongIssueE = 1'b1; RdE = 5'd3;
        tick();
        RdE = 5'd4;
        tick();
        idle();
        settle();
        check_eq("full_set", {31'd0, ScoreboardFull}, 32'd1);
        LongOpD = 1'b1;
        settle();
        check_eq("full_longop_stall", {31'd0, StallDecode}, 32'd1);
        idle(); LongDoneW = 1'b1; LongRdW = 5'd3;
        settle();
        check_eq("full_until_edge", {31'd0, ScoreboardFull}, 32'd1);
        tick();
        idle();
        settle();
        check_eq("full_released", {31'd0, ScoreboardFull}, 32'd0);
        LongDoneW = 1'b1; LongRdW = 5'd4;
        tick();
        idle();

        // Memory freeze over branch and load-use
        ResultSrcE = 2'b01; RdE = 5'd7; Rs1D = 5'd7;
        tick();
        MemStallM = 1'b1; PCSrcE = 1'b1;
        settle();
        check_eq("mem_freeze", {25'd0, ctl()}, {25'd0, CTL_MEM});
        tick();
        MemStallM = 1'b0;
        settle();
        check_eq("mem_release_flush", {25'd0, ctl()}, {25'd0, CTL_FLUSH});
        tick();
        idle();
        settle();
        check_eq("flush_cleared_bubbles", {25'd0, ctl()}, {25'd0, CTL_NONE});

        // Reset mid-stall with busy[9] and one bubble pending
        LongIssueE = 1'b1; RdE = 5'd9;
        tick();
        idle(); ResultSrcE = 2'b01; RdE = 5'd7; Rs2D = 5'd7;
        tick();
        idle(); Rs1D = 5'd9; rst = 1'b1;
        settle();
        check_eq("rst_mid_stall_ctl", {25'd0, ctl()}, {25'd0, CTL_NONE});
        tick();
        rst = 1'b0;
        settle();
        check_eq("post_rst_ctl", {25'd0, ctl()}, {25'd0, CTL_NONE});
        check_eq("post_rst_perf", StallCycleCount, 32'd0);
        tick();
        MemStallM = 1'b1;
        tick(); tick(); tick();
        MemStallM = 1'b0;
        settle();
`ifdef HAZARD_PERF_CNT_EN
        check_eq("perf_three", StallCycleCount, 32'd3);
`else
        check_eq("perf_tied_zero", StallCycleCount, 32'd0);
`endif
        $display("CHECKS %0d ERRORS %0d", chk_count, err_count);
        $finish;
    end

endmodule
